pkt_gen_tx_sched: RTL and testbench

- Consumes the 4-bit per-queue `enable` vector from the packet-generator control register block.
- Decides which generator queue launches its next stored packet.
- Round-robin among enabled queues that have a packet ready. Enforces a per-queue iteration limit and a global inter-packet gap.
- Sits between the control registers and the per-queue SRAM packet readers / output arbiter.

---
 rtl/pkt_gen_tx_sched.sv | 186 ++++++++++++++++++
 tb/tb_pkt_gen_tx_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_gen_tx_sched.sv
// pkt_gen_tx_sched: round-robin launch scheduler for the packet-generator queues with a
// per-queue iteration limit and a global inter-packet gap. Optional macro: PKT_GEN_TX_SCHED_PKT_CNT_EN.
module pkt_gen_tx_sched #(
    parameter int NUM_QUEUES = 4,
    parameter int ITER_WIDTH = 16,
    parameter int GAP_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_QUEUES-1:0]            enable,
    input  logic [NUM_QUEUES*ITER_WIDTH-1:0] iter_limit,
    input  logic [GAP_WIDTH-1:0]             gap_cycles,
    input  logic [NUM_QUEUES-1:0]            pkt_rdy,
    input  logic                             pkt_done,
    output logic [NUM_QUEUES-1:0]            pkt_start,
    output logic [1:0]                       active_q,
    output logic                             busy,
    output logic [NUM_QUEUES-1:0]            q_done,
    output logic [NUM_QUEUES*32-1:0]         pkt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [1:0]              rr_ptr_r;
    logic [GAP_WIDTH-1:0]    gap_cnt_r;
    logic [ITER_WIDTH-1:0]   sent_r      [NUM_QUEUES];
    logic [ITER_WIDTH-1:0]   sent_sat_s  [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]   hit_limit_s;
    logic [NUM_QUEUES-1:0]   eligible_s;
    logic                    grant_vld_s;
    logic [1:0]              grant_idx_s;
    logic                    done_evt_s;
    logic [NUM_QUEUES-1:0]   start_nx_s;
    logic                    busy_nx_s;
    logic [NUM_QUEUES-1:0]   pkt_start_r;
    logic [1:0]              active_q_r;
    logic                    busy_r;
    logic [NUM_QUEUES-1:0]   q_done_r;

    assign eligible_s = enable & pkt_rdy & ~q_done_r;

    // Round-robin search: first eligible queue after the last grant, with wrap.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = 2'd0;
        for (int i = 1; i <= NUM_QUEUES; i++) begin
            int  idx_v;
            logic take_v;
            idx_v       = (int'(rr_ptr_r) + i) % NUM_QUEUES;
            take_v      = eligible_s[idx_v] & ~grant_vld_s;
            grant_idx_s = take_v ? 2'(idx_v) : grant_idx_s;
            grant_vld_s = grant_vld_s | eligible_s[idx_v];
        end
    end

    // Saturating increment and limit compare; the compare is one bit wider so a saturated counter never matches.
    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            logic [ITER_WIDTH-1:0] limit_v;
            logic [ITER_WIDTH:0]   sent_ext_v;
            limit_v        = iter_limit[q*ITER_WIDTH +: ITER_WIDTH];
            sent_ext_v     = {1'b0, sent_r[q]} + {{ITER_WIDTH{1'b0}}, 1'b1};
            hit_limit_s[q] = (limit_v != '0) && (sent_ext_v == {1'b0, limit_v});
            sent_sat_s[q]  = (sent_r[q] == '1) ? sent_r[q] : sent_ext_v[ITER_WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a zero gap counter in GAP also exits so the FSM cannot stall there.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) state_nx_s = ST_SEND;
                else             state_nx_s = ST_IDLE;
            end
            ST_SEND: begin
                if (pkt_done) state_nx_s = (gap_cycles == '0) ? ST_IDLE : ST_GAP;
                else          state_nx_s = ST_SEND;
            end
            ST_GAP: begin
                if (gap_cnt_r <= GAP_WIDTH'(1)) state_nx_s = ST_IDLE;
                else                            state_nx_s = ST_GAP;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode feeding the output registers.
    always_comb begin
        start_nx_s = '0;
        if ((state_r == ST_IDLE) && grant_vld_s) begin
            start_nx_s[grant_idx_s] = 1'b1;
        end else begin
            start_nx_s = '0;
        end
        busy_nx_s  = (state_nx_s == ST_SEND) || (state_nx_s == ST_GAP);
        done_evt_s = (state_r == ST_SEND) && pkt_done;
    end

    // Registered launch pulse, grant index, busy flag and rr pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_start_r <= '0;
            active_q_r  <= 2'd0;
            busy_r      <= 1'b0;
            rr_ptr_r    <= 2'(NUM_QUEUES - 1);
        end else begin
            pkt_start_r <= start_nx_s;
            busy_r      <= busy_nx_s;
            if (start_nx_s != '0) begin
                active_q_r <= grant_idx_s;
                rr_ptr_r   <= grant_idx_s;
            end
        end
    end

    // Inter-packet gap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt_r <= '0;
        end else if (done_evt_s) begin
            gap_cnt_r <= gap_cycles;
        end else if ((state_r == ST_GAP) && (gap_cnt_r != '0)) begin
            gap_cnt_r <= gap_cnt_r - GAP_WIDTH'(1);
        end
    end

    // Per-queue iteration bookkeeping; a low enable clears and outranks a completing packet.
    always_ff @(posedge clk) begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (reset || !enable[q]) begin
                sent_r[q]   <= '0;
                q_done_r[q] <= 1'b0;
            end else if (done_evt_s && (active_q_r == 2'(q))) begin
                sent_r[q]   <= sent_sat_s[q];
                q_done_r[q] <= q_done_r[q] | hit_limit_s[q];
            end
        end
    end

`ifdef PKT_GEN_TX_SCHED_PKT_CNT_EN
    logic [31:0] pkt_cnt_r [NUM_QUEUES];

    // Lifetime per-queue packet counters; they survive enable toggling.
    always_ff @(posedge clk) begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (reset) begin
                pkt_cnt_r[q] <= 32'd0;
            end else if (done_evt_s && (active_q_r == 2'(q)) && (pkt_cnt_r[q] != 32'hFFFF_FFFF)) begin
                pkt_cnt_r[q] <= pkt_cnt_r[q] + 32'd1;
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        pkt_cnt = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            pkt_cnt[q*32 +: 32] = pkt_cnt_r[q];
        end
    end
`else
    assign pkt_cnt = '0;
`endif

    assign pkt_start = pkt_start_r;
    assign active_q  = active_q_r;
    assign busy      = busy_r;
    assign q_done    = q_done_r;

endmodule

// File: tb/tb_pkt_gen_tx_sched.sv
// Scoreboard bench for pkt_gen_tx_sched: a transaction-level model predicts launches and status,
// a negedge monitor compares them against the DUT.
module tb_pkt_gen_tx_sched;
    localparam int NQ = 4;
    localparam int IW = 16;
    localparam int GW = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [NQ-1:0]       enable;
    logic [NQ*IW-1:0]    iter_limit;
    logic [GW-1:0]       gap_cycles;
    logic [NQ-1:0]       pkt_rdy;
    logic                pkt_done;
    logic [NQ-1:0]       pkt_start;
    logic [1:0]          active_q;
    logic                busy;
    logic [NQ-1:0]       q_done;
    logic [NQ*32-1:0]    pkt_cnt;

    always #5 clk = ~clk;

    pkt_gen_tx_sched #(.NUM_QUEUES(NQ), .ITER_WIDTH(IW), .GAP_WIDTH(GW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .iter_limit(iter_limit),
        .gap_cycles(gap_cycles), .pkt_rdy(pkt_rdy), .pkt_done(pkt_done),
        .pkt_start(pkt_start), .active_q(active_q), .busy(busy),
        .q_done(q_done), .pkt_cnt(pkt_cnt)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit checking = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: packets, time stamps and counts rather than FSM states.
    bit     m_in_send;
    int     m_q, m_last, m_rr, m_free_at, m_age;
    int     m_sent [NQ];
    bit     m_done [NQ];
    longint m_cnt  [NQ];
    int     dut_tally [NQ];

    typedef struct { int cyc; int q; } start_t;
    typedef struct { int cyc; bit busy; logic [NQ-1:0] qd; int aq; logic [NQ*32-1:0] cnt; } stat_t;
    start_t sq [$];
    stat_t  stq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_in_send = 1'b0;
        m_last    = 0;
        m_rr      = NQ - 1;
        m_free_at = cyc + 1;
        m_age     = 0;
        for (int q = 0; q < NQ; q++) begin
            m_sent[q] = 0;
            m_done[q] = 1'b0;
            m_cnt[q]  = 0;
        end
    endtask

    // Drive one cycle of inputs and advance the model by that cycle.
    task automatic tick(input bit rst, input logic [NQ-1:0] en, input logic [NQ-1:0] rdy,
                        input logic [NQ*IW-1:0] lim, input int gap, input int lat, input bit stray);
        stat_t  st;
        start_t s;
        bit     dn;
        bit     found;
        int     pick;
        int     idx;
        int     l;
        @(posedge clk);
        #1;
        reset      = rst;
        enable     = en;
        pkt_rdy    = rdy;
        iter_limit = lim;
        gap_cycles = GW'(gap);
        if (m_in_send) m_age++;
        dn = !rst && ((m_in_send && (m_age > lat)) ||
                      (!m_in_send && stray && ($urandom_range(0, 3) == 0)));
        pkt_done = dn;
        if (checking) begin
            st.cyc  = cyc;
            st.busy = m_in_send || (cyc < m_free_at);
            st.aq   = m_last;
            st.cnt  = '0;
            for (int q = 0; q < NQ; q++) begin
                st.qd[q] = m_done[q];
`ifdef PKT_GEN_TX_SCHED_PKT_CNT_EN
                st.cnt[q*32 +: 32] = 32'(m_cnt[q]);
`endif
            end
            stq.push_back(st);
        end
        if (rst) begin
            model_reset();
            checking = 1'b1;
        end else begin
            if (m_in_send && dn) begin
                if (en[m_q]) begin
                    l = int'(lim[m_q*IW +: IW]);
                    if ((l != 0) && (m_sent[m_q] + 1 == l)) m_done[m_q] = 1'b1;
                    if (m_sent[m_q] < 65535) m_sent[m_q]++;
                end
                if (m_cnt[m_q] < 64'hFFFF_FFFF) m_cnt[m_q]++;
                m_in_send = 1'b0;
                m_free_at = cyc + 1 + gap;
            end else if (!m_in_send && (cyc >= m_free_at)) begin
                found = 1'b0;
                pick  = 0;
                for (int k = 1; k <= NQ; k++) begin
                    idx = (m_rr + k) % NQ;
                    if (!found && en[idx] && rdy[idx] && !m_done[idx]) begin
                        found = 1'b1;
                        pick  = idx;
                    end
                end
                if (found) begin
                    s.cyc = cyc + 1;
                    s.q   = pick;
                    sq.push_back(s);
                    m_in_send = 1'b1;
                    m_age     = 0;
                    m_q       = pick;
                    m_rr      = pick;
                    m_last    = pick;
                end
            end
            for (int q = 0; q < NQ; q++) begin
                if (!en[q]) begin
                    m_sent[q] = 0;
                    m_done[q] = 1'b0;
                end
            end
        end
    endtask

    task automatic clear_tally();
        for (int q = 0; q < NQ; q++) dut_tally[q] = 0;
    endtask

    // Monitor: pops expected status every cycle and expected launches when due.
    stat_t  mon_st;
    start_t mon_s;
    always @(negedge clk) begin
        if (stq.size() > 0 && stq[0].cyc == cyc) begin
            mon_st = stq.pop_front();
            check("busy", 64'(busy), 64'(mon_st.busy));
            check("q_done", 64'(q_done), 64'(mon_st.qd));
            check("active_q", 64'(active_q), 64'(mon_st.aq));
            for (int q = 0; q < NQ; q++)
                check("pkt_cnt", 64'(pkt_cnt[q*32 +: 32]), 64'(mon_st.cnt[q*32 +: 32]));
        end
        if (checking) begin
            for (int q = 0; q < NQ; q++) if (pkt_start[q] === 1'b1) dut_tally[q]++;
        end
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
            mon_s = sq.pop_front();
            check("pkt_start", 64'(pkt_start), 64'(1) << mon_s.q);
        end else if (checking && pkt_start !== '0) begin
            check("pkt_start_spurious", 64'(pkt_start), 64'd0);
        end
    end

    logic [NQ*IW-1:0] lim_v;
    logic [NQ-1:0]    en_v;
    logic [NQ-1:0]    rdy_v;
    int               gap_v;

    initial begin
        reset = 1'b1; enable = '0; pkt_rdy = '0; iter_limit = '0; gap_cycles = '0; pkt_done = 1'b0;
        repeat (2) @(posedge clk);

        // Single queue with limit 3, done 5 cycles after each start.
        lim_v = '0; lim_v[0*IW +: IW] = 16'd3;
        tick(1'b1, 4'b0000, 4'b0000, '0, 0, 0, 1'b0);
        clear_tally();
        repeat (60) tick(1'b0, 4'b0001, 4'b1111, lim_v, 0, 5, 1'b0);
        check("p1_starts_q0", 64'(dut_tally[0]), 64'd3);
        check("p1_q_done", 64'(q_done), 64'(4'b0001));
        check("p1_busy", 64'(busy), 64'd0);

        // Round robin over 0,1,3.
        tick(1'b1, 4'b0000, 4'b0000, '0, 0, 0, 1'b0);
        clear_tally();
        for (int i = 0; i < 60; i++) tick(1'b0, 4'b1011, 4'b1111, '0, 0, $urandom_range(0, 3), 1'b1);
        check("p2_q2_never", 64'(dut_tally[2]), 64'd0);
        check("p2_q3_started", 64'(dut_tally[3] > 0), 64'd1);

        // Gap of 4 on a single queue; launch timing is checked by the scoreboard.
        tick(1'b1, 4'b0000, 4'b0000, '0, 0, 0, 1'b0);
        repeat (50) tick(1'b0, 4'b0010, 4'b1111, '0, 4, 2, 1'b1);

        // Enable dropped while queue 1 is sending, then re-enabled with limit 2.
        tick(1'b1, 4'b0000, 4'b0000, '0, 0, 0, 1'b0);
        clear_tally();
        for (int i = 0; i < 10 && !m_in_send; i++) tick(1'b0, 4'b0010, 4'b1111, '0, 0, 1000, 1'b0);
        repeat (2) tick(1'b0, 4'b0000, 4'b1111, '0, 0, 1000, 1'b0);
        tick(1'b0, 4'b0000, 4'b1111, '0, 0, 0, 1'b0);
        lim_v = '0; lim_v[1*IW +: IW] = 16'd2;
        repeat (40) tick(1'b0, 4'b0010, 4'b1111, lim_v, 0, 3, 1'b0);
        check("p4_starts_q1", 64'(dut_tally[1]), 64'd3);
        check("p4_q_done", 64'(q_done), 64'(4'b0010));

        // Reset during SEND with a long gap; queue 0 must be the first grant afterwards.
        tick(1'b1, 4'b0000, 4'b0000, '0, 0, 0, 1'b0);
        for (int i = 0; i < 10 && !m_in_send; i++) tick(1'b0, 4'b0010, 4'b1111, '0, 10, 3, 1'b0);
        tick(1'b0, 4'b0010, 4'b1111, '0, 10, 1000, 1'b0);
        tick(1'b1, 4'b0011, 4'b1111, '0, 10, 1000, 1'b0);
        repeat (30) tick(1'b0, 4'b0011, 4'b1111, '0, 10, 3, 1'b1);

        // Randomised traffic.
        en_v = 4'($urandom); lim_v = '0; gap_v = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) en_v = en_v ^ (4'b0001 << $urandom_range(0, 3));
            rdy_v = 4'($urandom);
            if ($urandom_range(0, 63) == 0)
                for (int q = 0; q < NQ; q++) lim_v[q*IW +: IW] = IW'($urandom_range(0, 4));
            if ($urandom_range(0, 31) == 0) gap_v = $urandom_range(0, 3);
            tick($urandom_range(0, 299) == 0, en_v, rdy_v, lim_v, gap_v, $urandom_range(0, 4), 1'b1);
        end

        // Seven packets on queue 2, then toggle enable[2]; the lifetime count must stay.
        tick(1'b1, 4'b0000, 4'b0000, '0, 0, 0, 1'b0);
        clear_tally();
        lim_v = '0; lim_v[2*IW +: IW] = 16'd7;
        repeat (100) tick(1'b0, 4'b0100, 4'b1111, lim_v, 1, 1, 1'b0);
        repeat (3) tick(1'b0, 4'b0000, 4'b0000, lim_v, 1, 1, 1'b0);
        repeat (3) tick(1'b0, 4'b0100, 4'b0000, lim_v, 1, 1, 1'b0);
        check("p7_starts_q2", 64'(dut_tally[2]), 64'd7);
`ifdef PKT_GEN_TX_SCHED_PKT_CNT_EN
        check("p7_pkt_cnt_q2", 64'(pkt_cnt[2*32 +: 32]), 64'd7);
`else
        check("p7_pkt_cnt_zero", 64'(pkt_cnt != '0), 64'd0);
`endif

        repeat (3) tick(1'b0, 4'b0000, 4'b0000, '0, 0, 0, 1'b0);
        @(negedge clk);
        check("pending_starts", 64'(sq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
